keymap_decoder: RTL

KEYMAP_DECODER -- requirements
Module: keymap_decoder

---
 rtl/keymap_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/keymap_decoder.sv
// Maps PS/2 key events onto held button outputs through a writable scancode table.
// Also stretches presses of the coin button into fixed-length coin pulses.
module keymap_decoder #(
   parameter int NUM_BTN     = 16,
   parameter int COIN_IDX    = 10,
   parameter int COIN_CYCLES = 250000
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [10:0]        ps2_key,
   input  logic               map_wr,
   input  logic [4:0]         map_addr,
   input  logic [8:0]         map_data,
   input  logic               release_all,
   output logic [NUM_BTN-1:0] btn,
   output logic               coin
);

   localparam int CW = $clog2(COIN_CYCLES);

   typedef struct packed {
      logic       valid;
      logic       ext;
      logic [7:0] code;
   } entry_t;

   typedef enum logic [1:0] {IDLE, PULSE, WAITREL} coin_state_t;

   entry_t             tbl [NUM_BTN];
   logic [NUM_BTN-1:0] hit;
   logic               tog_q;
   logic               primed;
   logic               evt_q;
   logic [9:0]         key_q;
   logic               evt_det;

   coin_state_t        state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               coin_prev;

   // Per-entry storage and compare; addresses outside the table match no entry.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ent
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset)
            tbl[i] <= '0;
         else if (map_wr && map_addr == 5'(i))
            tbl[i] <= {map_data[7:0] != 8'd0, map_data};
      end
      assign hit[i] = tbl[i].valid && ({tbl[i].ext, tbl[i].code} == key_q[8:0]);
   end

   assign evt_det = primed && (ps2_key[10] != tog_q);

   // First edge after reset only samples the toggle bit.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         tog_q  <= 1'b0;
         primed <= 1'b0;
         evt_q  <= 1'b0;
         key_q  <= '0;
      end else begin
         tog_q  <= ps2_key[10];
         primed <= 1'b1;
         evt_q  <= evt_det;
         if (evt_det)
            key_q <= ps2_key[9:0];
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         btn <= '0;
      else if (release_all)
         btn <= '0;
      else if (evt_q) begin
         for (int i = 0; i < NUM_BTN; i++)
            if (hit[i])
               btn[i] <= key_q[9];
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         coin_prev <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         coin_prev <= btn[COIN_IDX];
      end
   end

   // coin decodes straight from state so reset drops it without a clock.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      coin    = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn[COIN_IDX] && !coin_prev) begin
               state_d = PULSE;
               cnt_d   = CW'(COIN_CYCLES - 1);
            end
         end
         PULSE: begin
            coin = 1'b1;
            if (cnt_q == '0)
               state_d = btn[COIN_IDX] ? WAITREL : IDLE;
            else
               cnt_d = cnt_q - 1'b1;
         end
         WAITREL: begin
            if (!btn[COIN_IDX])
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
